serial_add_scheduler: RTL and testbench

Shares one full-adder cell between two requesters. Each accepted operation is computed bit-serially, LSB first, one bit per clock, with the carry held in a flop between bits. A round-robin arbiter picks which requester is served next, and a valid/ready result port returns sum, carry-out and requester ID. The block sits between operand producers and any downstream consumer that needs WIDTH-bit additions but cannot afford a parallel adder per requester.

---
 rtl/serial_add_scheduler.sv | 124 ++++++++++++
 tb/tb_serial_add_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: one shared full-adder cell serves two requesters.
// The operation is computed bit-serially, LSB first, with the carry held in a flop.
// Round-robin arbitration happens in IDLE. The result is returned on a valid/ready port.
module serial_add_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             carry_next;
  logic             bit_s;
  logic             id_q;
  logic             last_grant;
  logic             last_bit;
  logic             accept;

  // A tie goes to the requester that was not granted last. Both readies are held low during reset.
  assign req0_ready = rst_n & (state == IDLE) & req0_valid & (~req1_valid | last_grant);
  assign req1_ready = rst_n & (state == IDLE) & req1_valid & (~req0_valid | ~last_grant);
  assign accept     = req0_ready | req1_ready;
  assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

  // This is the shared full-adder cell. It also forms the next sum register, with the new bit at the MSB.
  always_comb begin
    bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (carry & a_sh[0]);
    sum_next   = sum_sh >> 1;
    sum_next[WIDTH-1] = bit_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, run WIDTH bit cycles, then hold in DONE until the handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, serial shift, result capture and result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      bit_cnt    <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= req1_ready ? req1_a  : req0_a;
            b_sh       <= req1_ready ? req1_b  : req0_b;
            carry      <= req1_ready ? req1_ci : req0_ci;
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            bit_cnt    <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= sum_next;
          carry   <= carry_next;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            res_sum   <= sum_next;
            res_cout  <= carry_next;
            res_id    <= id_q;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Testbench for serial_add_scheduler.
// A cycle-level reference model predicts the grants and pushes the expected sums into a scoreboard.
// A separate monitor checks whatever result the DUT presents against the scoreboard.
module tb_serial_add_scheduler;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ci;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ci;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;

  int   vectors     = 0;
  int   miscompares = 0;

  op_t  pend0[$];
  op_t  pend1[$];
  res_t sb[$];

  int   m_phase = 0;
  int   m_left  = 0;
  logic m_last  = 1'b1;
  logic acc0    = 1'b0;
  logic acc1    = 1'b0;

  serial_add_scheduler #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ci    (req0_ci),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ci    (req1_ci),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the block is either idle, busy for WIDTH bit cycles, or holding a result.
  // When it is idle, ties go to the requester that was not served last.
  always @(negedge clk) begin
    logic e0;
    logic e1;
    logic [WIDTH:0] tot;
    op_t  op;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst_n && m_phase == 0) begin
      e0 = req0_valid && (!req1_valid || m_last == 1'b1);
      e1 = req1_valid && (!req0_valid || m_last == 1'b0);
    end
    checkOutput("req0_ready", req0_ready, e0);
    checkOutput("req1_ready", req1_ready, e1);
    checkOutput("res_valid", res_valid, m_phase == 2);
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      sb.delete();
      acc0    = 1'b0;
      acc1    = 1'b0;
    end else begin
      case (m_phase)
        0: if (e0 || e1) begin
          op  = e1 ? op_t'{req1_a, req1_b, req1_ci} : op_t'{req0_a, req0_b, req0_ci};
          tot = {1'b0, op.a} + {1'b0, op.b} + {{WIDTH{1'b0}}, op.ci};
          sb.push_back(res_t'{tot[WIDTH-1:0], tot[WIDTH], e1});
          m_last  = e1;
          m_phase = 1;
          m_left  = WIDTH;
          if (e1) acc1 = 1'b1;
          else    acc0 = 1'b1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        2: if (res_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor: compares every presented result with the head of the scoreboard, and pops it on the handshake.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_result: got res_valid=1, expected no pending result at %0t", $time);
      end else begin
        r = sb[0];
        checkOutput("res_sum", res_sum, r.sum);
        checkOutput("res_cout", res_cout, r.cout);
        checkOutput("res_id", res_id, r.id);
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  // Feeds the pending operations to both requesters and drives res_ready.
  // mode 0 ties res_ready high, mode 1 randomizes it, and mode 2 stalls the first result for about 10 cycles.
  task automatic applyStimulus(input int budget, input int mode);
    int  cyc;
    int  stall;
    op_t op;
    cyc   = 0;
    stall = 0;
    res_ready = (mode != 2);
    while ((pend0.size() != 0 || pend1.size() != 0 || req0_valid || req1_valid || sb.size() != 0)
           && cyc < budget) begin
      @(posedge clk); #1;
      if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
      if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
      if (!req0_valid && pend0.size() != 0) begin
        op = pend0.pop_front();
        req0_a = op.a; req0_b = op.b; req0_ci = op.ci; req0_valid = 1'b1;
      end
      if (!req1_valid && pend1.size() != 0) begin
        op = pend1.pop_front();
        req1_a = op.a; req1_b = op.b; req1_ci = op.ci; req1_valid = 1'b1;
      end
      if (mode == 1) res_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (res_valid) stall++;
        res_ready = (stall >= 10);
      end
      cyc++;
    end
    if (cyc >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: got %0d results outstanding after %0d cycles, expected 0", sb.size(), cyc);
    end
  endtask

  // Main sequence: reset, directed cases, abort, exhaustive and random.
  initial begin
    logic [2*WIDTH:0] v;
    rst_n      = 1'b0;
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h1; req0_ci = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'hA; req1_ci = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_sum", res_sum, 0);
    checkOutput("rst_res_cout", res_cout, 0);
    checkOutput("rst_res_id", res_id, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    rst_n = 1'b1;
    applyStimulus(200, 0);

    // Contention with continuous valid on both requesters.
    pend0.push_back(op_t'{4'h1, 4'h2, 1'b0});
    pend0.push_back(op_t'{4'h7, 4'h8, 1'b1});
    pend1.push_back(op_t'{4'h9, 4'h9, 1'b0});
    pend1.push_back(op_t'{4'hC, 4'h3, 1'b1});
    applyStimulus(200, 0);

    // Backpressure while the other requester keeps its valid high.
    pend0.push_back(op_t'{4'hB, 4'h6, 1'b1});
    pend1.push_back(op_t'{4'h2, 4'h2, 1'b0});
    applyStimulus(300, 2);

    // Abort in the second RUN cycle.
    res_ready = 1'b1;
    @(posedge clk); #1;
    req0_a = 4'hE; req0_b = 4'hE; req0_ci = 1'b1; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; acc0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_res_sum", res_sum, 0);
    checkOutput("abort_res_cout", res_cout, 0);
    rst_n = 1'b1;
    pend0.push_back(op_t'{4'h3, 4'h4, 1'b0});
    applyStimulus(200, 0);

    // All (a, b, ci) combinations, alternating requesters, random res_ready.
    for (int i = 0; i < (1 << (2 * WIDTH + 1)); i++) begin
      v = (2*WIDTH+1)'(i);
      if (i % 2 == 0) pend0.push_back(op_t'{v[WIDTH-1:0], v[2*WIDTH-1:WIDTH], v[2*WIDTH]});
      else            pend1.push_back(op_t'{v[WIDTH-1:0], v[2*WIDTH-1:WIDTH], v[2*WIDTH]});
    end
    applyStimulus(20000, 1);

    // Random operands, with each operation sent to a random requester.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        pend0.push_back(op_t'{WIDTH'($urandom), WIDTH'($urandom), 1'($urandom)});
      else
        pend1.push_back(op_t'{WIDTH'($urandom), WIDTH'($urandom), 1'($urandom)});
    end
    applyStimulus(3000, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
